// File: rtl/mcp4921_rx.sv
// Receiving end of the MCP4921 DAC link: SPI slave that decodes 16-bit write
// commands, models the input/output register pair, and counts good/bad frames.
module mcp4921_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nres,
    input  logic                  SCK,
    input  logic                  nCS,
    input  logic                  SDI,
    input  logic                  nLDAC,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  ldac_pulse,
    output logic [11:0]           dac_code,
    output logic                  dac_buf,
    output logic                  dac_gain1x,
    output logic                  dac_shdn_n,
    output logic [DATA_WIDTH-1:0] frame_cnt,
    output logic [DATA_WIDTH-1:0] err_cnt
);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        CHECK     = 2'd3
    } state_t;

    localparam int I_SCK  = 0;
    localparam int I_NCS  = 1;
    localparam int I_SDI  = 2;
    localparam int I_LDAC = 3;

    localparam logic [4:0]            BITS_MAX = 5'd17;
    localparam logic [4:0]            BITS_OK  = 5'd16;
    localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;

    // Each chain: [SYNC_STAGES-1] is the synchronised level, [SYNC_STAGES]
    // is that level one clk later for edge detection.
    logic [3:0][SYNC_STAGES:0] sync_q;
    logic [3:0]                pins;

    logic sck_s, sck_p, ncs_s, ncs_p, sdi_p, ldac_s, ldac_p;
    logic sck_rise, ncs_rise, ldac_fall;

    state_t                state_q, state_d;
    logic [15:0]           shift_q, shift_d;
    logic [4:0]            bitcnt_q, bitcnt_d;
    logic [14:0]           in_q, in_d;
    logic [14:0]           out_q, out_d;
    logic                  auto_q, auto_d;
    logic                  fv_q, fv_d;
    logic                  fe_q, fe_d;
    logic                  lp_q, lp_d;
    logic [DATA_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [DATA_WIDTH-1:0] ecnt_q, ecnt_d;
    logic                  check, good, xfer;

    assign pins = {nLDAC, SDI, nCS, SCK};

    always_ff @(posedge clk) begin
        if (!nres) begin
            sync_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-1:0], pins[i]};
            end
        end
    end

    assign sck_s  = sync_q[I_SCK][SYNC_STAGES-1];
    assign sck_p  = sync_q[I_SCK][SYNC_STAGES];
    assign ncs_s  = sync_q[I_NCS][SYNC_STAGES-1];
    assign ncs_p  = sync_q[I_NCS][SYNC_STAGES];
    assign sdi_p  = sync_q[I_SDI][SYNC_STAGES];
    assign ldac_s = sync_q[I_LDAC][SYNC_STAGES-1];
    assign ldac_p = sync_q[I_LDAC][SYNC_STAGES];

    assign sck_rise  = sck_s & ~sck_p;
    assign ncs_rise  = ncs_s & ~ncs_p;
    assign ldac_fall = ~ldac_s & ldac_p;

    // Frame FSM. IDLE starts on the nCS low level rather than the fall edge,
    // so a fall that lands in the CHECK cycle is still picked up one clk later.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        check    = 1'b0;
        good     = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (ncs_s) state_d = IDLE;
            end
            IDLE: begin
                if (!ncs_s) begin
                    shift_d  = '0;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    shift_d = {shift_q[14:0], sdi_p};
                    if (bitcnt_q != BITS_MAX) bitcnt_d = bitcnt_q + 5'd1;
                end
                if (ncs_rise) state_d = CHECK;
            end
            CHECK: begin
                check   = 1'b1;
                good    = (bitcnt_q == BITS_OK) && !shift_q[15];
                state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // A fall edge during a good CHECK is absorbed by the auto-transfer one clk
    // later, so the output register only ever receives the new word once.
    always_comb begin
        xfer   = auto_q | (ldac_fall & ~good);
        auto_d = good & ~ldac_s;
        in_d   = good ? shift_q[14:0] : in_q;
        out_d  = xfer ? in_q : out_q;
        fv_d   = good;
        fe_d   = check & ~good;
        lp_d   = xfer;
        fcnt_d = fcnt_q;
        ecnt_d = ecnt_q;
        if (good && fcnt_q != CNT_MAX) fcnt_d = fcnt_q + DATA_WIDTH'(1);
        if (check && !good && ecnt_q != CNT_MAX) ecnt_d = ecnt_q + DATA_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!nres) begin
            state_q  <= WAIT_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            in_q     <= '0;
            out_q    <= '0;
            auto_q   <= 1'b0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            lp_q     <= 1'b0;
            fcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            in_q     <= in_d;
            out_q    <= out_d;
            auto_q   <= auto_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            lp_q     <= lp_d;
            fcnt_q   <= fcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign ldac_pulse  = lp_q;
    assign dac_buf     = out_q[14];
    assign dac_gain1x  = out_q[13];
    assign dac_shdn_n  = out_q[12];
    assign dac_code    = out_q[11:0];
    assign frame_cnt   = fcnt_q;
    assign err_cnt     = ecnt_q;

endmodule

// File: tb/tb_mcp4921_rx.sv
// Bench for mcp4921_rx: drives SPI frames and nLDAC, predicts every output
// cycle from pin-level latencies and frame decode rules.
module tb_mcp4921_rx;

    localparam int DW   = 8;
    localparam int SY   = 2;
    localparam int HMAX = 100000;

    logic          clk = 1'b0;
    logic          nres = 1'b0;
    logic          SCK = 1'b0;
    logic          nCS = 1'b1;
    logic          SDI = 1'b0;
    logic          nLDAC = 1'b1;
    logic          frame_valid, frame_err, ldac_pulse;
    logic [11:0]   dac_code;
    logic          dac_buf, dac_gain1x, dac_shdn_n;
    logic [DW-1:0] frame_cnt, err_cnt;

    mcp4921_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SY)) dut (
        .clk(clk), .nres(nres), .SCK(SCK), .nCS(nCS), .SDI(SDI), .nLDAC(nLDAC),
        .frame_valid(frame_valid), .frame_err(frame_err), .ldac_pulse(ldac_pulse),
        .dac_code(dac_code), .dac_buf(dac_buf), .dac_gain1x(dac_gain1x),
        .dac_shdn_n(dac_shdn_n), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lp_seen = 0;
    int fv_seen = 0;
    bit aborted = 1'b0;

    // Pin history per clk cycle and frame outcomes keyed by the cycle they show.
    bit          ldac_h [0:HMAX-1];
    bit          rst_h  [0:HMAX-1];
    bit          fr_ev  [0:HMAX-1];
    bit          fr_ok  [0:HMAX-1];
    logic [14:0] fr_dat [0:HMAX-1];

    logic [14:0]   m_in = '0;
    logic [14:0]   m_out = '0;
    logic [DW-1:0] m_fc = '0;
    logic [DW-1:0] m_ec = '0;
    bit e_fv, e_fe, e_lp, fall, autox, good_now;
    int k;

    always @(posedge clk) begin
        ldac_h[cyc] = nLDAC;
        rst_h[cyc]  = nres;
        cyc = cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        k = cyc;
        e_fv = 1'b0; e_fe = 1'b0; e_lp = 1'b0;
        if (!rst_h[k-1]) begin
            m_in = '0; m_out = '0; m_fc = '0; m_ec = '0;
        end else begin
            good_now = fr_ev[k] && fr_ok[k];
            fall = 1'b0; autox = 1'b0;
            if (k >= SY + 2) begin
                fall  = !ldac_h[k-SY-1] && ldac_h[k-SY-2];
                autox = fr_ev[k-1] && fr_ok[k-1] && !ldac_h[k-SY-2];
            end
            if (autox || (fall && !good_now)) begin
                e_lp = 1'b1;
                m_out = m_in;
            end
            if (fr_ev[k]) begin
                if (fr_ok[k]) begin
                    e_fv = 1'b1;
                    m_in = fr_dat[k];
                    if (m_fc != '1) m_fc = m_fc + 1'b1;
                end else begin
                    e_fe = 1'b1;
                    if (m_ec != '1) m_ec = m_ec + 1'b1;
                end
            end
        end
        if (ldac_pulse === 1'b1) lp_seen++;
        if (frame_valid === 1'b1) fv_seen++;
        n_cmp++;
        if ({frame_valid, frame_err, ldac_pulse} !== {e_fv, e_fe, e_lp} ||
            {dac_buf, dac_gain1x, dac_shdn_n, dac_code} !== m_out ||
            frame_cnt !== m_fc || err_cnt !== m_ec) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: got fv=%0b fe=%0b lp=%0b word=%04h fc=%0d ec=%0d, expected fv=%0b fe=%0b lp=%0b word=%04h fc=%0d ec=%0d",
                     k, frame_valid, frame_err, ldac_pulse,
                     {dac_buf, dac_gain1x, dac_shdn_n, dac_code}, frame_cnt, err_cnt,
                     e_fv, e_fe, e_lp, m_out, m_fc, m_ec);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rbit: bit position at which nres is pulsed (-1 for none).
    // ldac_chk: drop nLDAC one clk after nCS rises so its synced fall meets CHECK.
    task automatic send(input logic [31:0] w, input int nb, input int hp,
                        input int rbit, input bit ldac_chk);
        aborted = 1'b0;
        nCS = 1'b0;
        tick(4);
        for (int i = nb - 1; i >= 0; i--) begin
            SDI = w[i];
            tick(hp);
            SCK = 1'b1;
            if (nb - 1 - i == rbit) begin
                nres = 1'b0;
                aborted = 1'b1;
                tick(3);
                nres = 1'b1;
            end
            tick(hp);
            SCK = 1'b0;
        end
        tick(3);
        nCS = 1'b1;
        if (!aborted) begin
            fr_ev[cyc+SY+2]  = 1'b1;
            fr_ok[cyc+SY+2]  = (nb == 16) && !w[15];
            fr_dat[cyc+SY+2] = w[14:0];
        end
        if (ldac_chk) begin
            tick(1);
            nLDAC = 1'b0;
        end
        tick(6);
    endtask

    task automatic pulse_ldac();
        nLDAC = 1'b0;
        tick(3);
        nLDAC = 1'b1;
        tick(SY + 4);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lp0, fv0, nb, hp, mode;
        logic [31:0] w;

        tick(5);
        nres = 1'b1;
        tick(SY + 4);
        chk("reset_fcnt", frame_cnt, 0);
        chk("reset_ecnt", err_cnt, 0);
        chk("reset_code", dac_code, 0);
        chk("reset_shdn", dac_shdn_n, 0);

        // Good frame with nLDAC high, then manual latch.
        send(32'h3FFF, 16, 3, -1, 1'b0);
        chk("t1_fcnt", frame_cnt, 1);
        chk("t1_code_pre", dac_code, 0);
        pulse_ldac();
        chk("t1_code", dac_code, 'hFFF);
        chk("t1_gain", dac_gain1x, 1);
        chk("t1_shdn", dac_shdn_n, 1);
        chk("t1_buf", dac_buf, 0);
        chk("t1_model", m_out, 'h3FFF);

        // nLDAC held low: auto-transfer.
        nLDAC = 1'b0;
        tick(SY + 4);
        lp0 = lp_seen;
        send(32'h7123, 16, 4, -1, 1'b0);
        chk("t2_pulses", lp_seen - lp0, 1);
        chk("t2_code", dac_code, 'h123);
        chk("t2_buf", dac_buf, 1);
        chk("t2_gain", dac_gain1x, 1);
        chk("t2_shdn", dac_shdn_n, 1);
        nLDAC = 1'b1;
        tick(4);

        // Rejected frames: short, long, A/B=1.
        send(32'h00001234, 15, 3, -1, 1'b0);
        send(32'h0001ABCD, 17, 3, -1, 1'b0);
        send(32'h0000B456, 16, 3, -1, 1'b0);
        chk("t3_ecnt", err_cnt, 3);
        chk("t3_fcnt", frame_cnt, 2);
        pulse_ldac();
        chk("t3_code", dac_code, 'h123);

        // Reset mid-frame: that frame vanishes, next one is accepted.
        lp0 = lp_seen; fv0 = fv_seen;
        send(32'h3ABC, 16, 3, 8, 1'b0);
        chk("t4_fcnt", frame_cnt, 0);
        chk("t4_ecnt", err_cnt, 0);
        chk("t4_code", dac_code, 0);
        chk("t4_fv", fv_seen - fv0, 0);
        chk("t4_lp", lp_seen - lp0, 0);
        send(32'h3800, 16, 3, -1, 1'b0);
        pulse_ldac();
        chk("t4_code_after", dac_code, 'h800);
        chk("t4_fcnt_after", frame_cnt, 1);

        // Counter saturation.
        for (int i = 0; i < 256; i++) begin
            w = $urandom & 32'h7FFF;
            send(w, 16, 3, -1, 1'b0);
        end
        chk("t5_fcnt_sat", frame_cnt, 255);
        chk("t5_model_sat", m_fc, 255);

        // nLDAC fall coinciding with CHECK.
        lp0 = lp_seen;
        send(32'h3555, 16, 3, -1, 1'b1);
        chk("t6_pulses", lp_seen - lp0, 1);
        chk("t6_code", dac_code, 'h555);
        nLDAC = 1'b1;
        tick(4);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            w = $urandom & 32'h1FFFF;
            if ($urandom_range(0, 3) != 0) w[15] = 1'b0;
            mode = $urandom_range(0, 5);
            nb = (mode == 0) ? 15 : (mode == 1) ? 17 : 16;
            hp = $urandom_range(3, 5);
            mode = $urandom_range(0, 3);
            if (mode == 2) begin
                nLDAC = 1'b0;
                tick(SY + 4);
            end
            send(w, nb, hp, -1, mode == 3);
            if (mode == 1) pulse_ldac();
            if (mode >= 2) begin
                nLDAC = 1'b1;
                tick(4);
            end
        end

        tick(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcp4921_rx.md
# mcp4921_rx

Synthesisable receiving end of the MCP4921 DAC link: an SPI slave that samples the SCK/nCS/SDI/nLDAC lines produced by the DAC master and decodes each 16-bit MCP4921 write command exactly as the device does. It is used as an on-chip loopback/monitor of the DAC path and as the DAC stand-in in counter-board simulations. It exposes the decoded DAC state plus good/bad frame counters.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the frame and error counters
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (≥2)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- nres  in  1  reset, synchronous, active-low
- SCK  in  1  SPI clock, asynchronous to clk
- nCS  in  1  chip select, active-low, asynchronous
- SDI  in  1  serial data, MSB first, asynchronous
- nLDAC  in  1  latch strobe, active-low, asynchronous
- frame_valid  out  1  one-cycle pulse: good frame loaded into the input register
- frame_err  out  1  one-cycle pulse: frame rejected
- ldac_pulse  out  1  one-cycle pulse: input register transferred to the output register
- dac_code  out  12  output-register DAC code
- dac_buf  out  1  output-register BUF bit
- dac_gain1x  out  1  output-register GA bit (1 = 1x, 0 = 2x)
- dac_shdn_n  out  1  output-register SHDN bit (0 = shutdown)
- frame_cnt  out  DATA_WIDTH  good frames, saturating
- err_cnt  out  DATA_WIDTH  rejected frames, saturating

## Operation
- SCK, nCS, SDI, nLDAC each pass SYNC_STAGES flops, then one extra flop for edge detection.
- Frame word bits: [15] A/B, [14] BUF, [13] GA, [12] SHDN, [11:0] code.
- FSM states: WAIT_IDLE, IDLE, SHIFT, CHECK.
  - WAIT_IDLE: entered on reset; moves to IDLE once synced nCS is high. A frame already in progress at reset release is ignored completely.
  - IDLE: when nCS falls, clear the 16-bit shift register and the 5-bit bit counter, then go to SHIFT.
  - SHIFT: on each synced SCK rising edge, shift_reg <= {shift_reg[14:0], SDI} and increment the bit counter, which saturates at 17. SCK falling edges are ignored. When nCS rises, go to CHECK.
  - CHECK (one cycle), then IDLE:
    - Good frame (bit count == 16 and shift_reg[15] == 0): load the input register, pulse frame_valid, increment frame_cnt.
    - Any other frame: pulse frame_err, increment err_cnt, leave the input register unchanged.
- Output register transfer, with ldac_pulse:
  - on the synced nLDAC falling edge, or
  - in the cycle after a good CHECK, if synced nLDAC is low at that time.
- A repeated nLDAC falling edge with no new frame re-transfers the same value and still pulses.
- Counters stop at 2^DATA_WIDTH-1.

## Timing
- Reset values: all outputs 0, both registers 0, FSM in WAIT_IDLE.
- SCK high and low must each last at least 3 clk periods. Data is sampled on the synced SCK rise, so SDI must be stable ≥3 clk before and after that edge.
- Latency:
  - nCS rise at the pin → frame_valid/frame_err: SYNC_STAGES+2 clk.
  - Auto-transfer (nLDAC low at CHECK): ldac_pulse and output update 1 clk after frame_valid.
  - nLDAC fall at the pin → ldac_pulse and output update: SYNC_STAGES+1 clk.
- Simultaneous events:
  - nLDAC fall in the same cycle as CHECK: one transfer only, 1 clk later, carrying the new value.
  - nCS fall in the CHECK cycle: FSM is forced back to IDLE first; the new frame is detected on the following cycle, which is guaranteed because nCS high lasts ≥3 clk.
- nres low at any time takes priority over all other logic, including mid-frame and mid-transfer.

## Test plan
- Reset, then send 0x3FFF with nLDAC held high → frame_valid, frame_cnt=1, outputs still 0. Pulse nLDAC low → ldac_pulse, dac_code=0xFFF, dac_gain1x=1, dac_shdn_n=1, dac_buf=0.
- Hold nLDAC low and send 0x7123 → frame_valid, then exactly one ldac_pulse 1 clk later; dac_code=0x123, dac_buf=1, dac_gain1x=1, dac_shdn_n=1.
- Send a 15-bit frame, a 17-bit frame, and 0xB456 (A/B=1) → three frame_err pulses, err_cnt=3, input and output registers unchanged.
- Assert nres low in the middle of bit 8 of a frame and release it while nCS is still low → no pulses, all outputs 0. The next complete 0x3800 frame is accepted (dac_code=0x800 after nLDAC).
- Send 256 good frames with DATA_WIDTH=8 → frame_cnt saturates at 255.
- Drop nLDAC in the same clk as CHECK for 0x3555 → exactly one ldac_pulse, dac_code=0x555.
